// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared constants for the execute-stage issue controller:
//   - R-type funct codes recognised by the controller
//   - 3-bit ALU control codes
//   - 2-bit result-select codes
//   - issue FSM state encoding
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

    // R-type funct codes
    localparam logic [5:0] FUNCT_SLL   = 6'd0;
    localparam logic [5:0] FUNCT_JR    = 6'd8;
    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_ADD   = 6'd32;
    localparam logic [5:0] FUNCT_SUB   = 6'd34;
    localparam logic [5:0] FUNCT_AND   = 6'd36;
    localparam logic [5:0] FUNCT_OR    = 6'd37;
    localparam logic [5:0] FUNCT_SLT   = 6'd42;

    // ALU control codes
    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SUB = 3'b110;
    localparam logic [2:0] ALU_OP_SLT = 3'b111;

    // Result select codes
    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_HI  = 2'b01;
    localparam logic [1:0] MUX_LO  = 2'b10;
    localparam logic [1:0] MUX_SHT = 2'b11;

    // Issue FSM states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        WB   = 2'b10
    } state_t;

    // True for instructions that touch the multiplier or Hi/Lo
    function automatic logic needs_hilo(input logic [5:0] funct);
        return (funct == FUNCT_MULTU) || (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO);
    endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// ---------------------------------------------------------------------------
// alu_funct_decode
// Purely combinational decode of the EX-stage R-type funct into datapath
// controls. Invalid slots and unknown functs fall back to an ADD through
// the ALU path.
// Ports:
//   valid_i   in   EX instruction valid
//   funct_i   in   6-bit R-type funct
//   alu_op_o  out  3-bit ALU control code
//   mux_sel_o out  2-bit result select
//   sht_en_o  out  shifter select
// ---------------------------------------------------------------------------
module alu_funct_decode
    import alu_ctrl_pkg::*;
(
    input  logic       valid_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o,
    output logic [1:0] mux_sel_o,
    output logic       sht_en_o
);

    // funct to datapath control decode
    always_comb begin
        alu_op_o  = ALU_OP_ADD;
        mux_sel_o = MUX_ALU;
        sht_en_o  = 1'b0;
        if (valid_i) begin
            case (funct_i)
                FUNCT_AND:  alu_op_o  = ALU_OP_AND;
                FUNCT_OR:   alu_op_o  = ALU_OP_OR;
                FUNCT_ADD:  alu_op_o  = ALU_OP_ADD;
                FUNCT_JR:   alu_op_o  = ALU_OP_ADD;
                FUNCT_SUB:  alu_op_o  = ALU_OP_SUB;
                FUNCT_SLT:  alu_op_o  = ALU_OP_SLT;
                FUNCT_SLL: begin
                    sht_en_o  = 1'b1;
                    mux_sel_o = MUX_SHT;
                end
                FUNCT_MFHI: mux_sel_o = MUX_HI;
                FUNCT_MFLO: mux_sel_o = MUX_LO;
                default:    alu_op_o  = ALU_OP_ADD;
            endcase
        end else begin
            alu_op_o = ALU_OP_ADD;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Execute-stage controller for the shared ALU / MULTU / HiLo / shifter
// datapath. Decodes the EX funct, runs MULTU for MUL_CYCLES cycles, commits
// the product to Hi/Lo in a single write-back cycle, and stalls any
// multiplier/HiLo instruction that arrives while a multiply is in flight.
// Optional feature (macro STALL_CNT_EN): saturating 32-bit count of stalled
// cycles on stall_cnt_o.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-low reset
//   valid_i      in   EX instruction valid
//   funct_i      in   6-bit R-type funct
//   alu_op_o     out  ALU control code (combinational)
//   mux_sel_o    out  result select (combinational)
//   sht_en_o     out  shifter select (combinational)
//   multu_en_o   out  multiplier run enable (registered)
//   hi_we_o      out  Hi write strobe (registered)
//   lo_we_o      out  Lo write strobe (registered)
//   stall_o      out  freeze IF/ID/EX (combinational)
//   busy_o       out  multiply in flight (registered)
//   done_o       out  Hi/Lo commit pulse (registered)
//   stall_cnt_o  out  stalled-cycle count (STALL_CNT_EN only)
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o,
    output logic [1:0] mux_sel_o,
    output logic       sht_en_o,
    output logic       multu_en_o,
    output logic       hi_we_o,
    output logic       lo_we_o,
    output logic       stall_o,
    output logic       busy_o,
    output logic       done_o
`ifdef STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             multu_en_r;
    logic             hi_we_r;
    logic             lo_we_r;
    logic             busy_r;
    logic             done_r;
    logic             stall_s;
    logic             accept_s;

    alu_funct_decode u_decode (
        .valid_i   (valid_i),
        .funct_i   (funct_i),
        .alu_op_o  (alu_op_o),
        .mux_sel_o (mux_sel_o),
        .sht_en_o  (sht_en_o)
    );

    // Only multiplier/HiLo users wait; everything else flows past the multiply
    assign stall_s  = (state_r != IDLE) && valid_i && needs_hilo(funct_i);
    // A MULTU can only be taken from IDLE, where it never stalls
    assign accept_s = (state_r == IDLE) && valid_i && (funct_i == FUNCT_MULTU) && !stall_s;

    // Issue FSM: state, cycle counter and registered datapath strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            multu_en_r <= 1'b0;
            hi_we_r    <= 1'b0;
            lo_we_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    hi_we_r <= 1'b0;
                    lo_we_r <= 1'b0;
                    done_r  <= 1'b0;
                    if (accept_s) begin
                        state_r    <= MUL;
                        cnt_r      <= CNT_W'(MUL_CYCLES - 1);
                        multu_en_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= IDLE;
                        multu_en_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                MUL: begin
                    busy_r <= 1'b1;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r    <= WB;
                        multu_en_r <= 1'b0;
                        hi_we_r    <= 1'b1;
                        lo_we_r    <= 1'b1;
                        done_r     <= 1'b1;
                    end else begin
                        cnt_r      <= cnt_r - CNT_W'(1);
                        multu_en_r <= 1'b1;
                        hi_we_r    <= 1'b0;
                        lo_we_r    <= 1'b0;
                        done_r     <= 1'b0;
                    end
                end
                WB: begin
                    // Always return to IDLE so a waiting MULTU is accepted there
                    state_r    <= IDLE;
                    multu_en_r <= 1'b0;
                    hi_we_r    <= 1'b0;
                    lo_we_r    <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= {CNT_W{1'b0}};
                    multu_en_r <= 1'b0;
                    hi_we_r    <= 1'b0;
                    lo_we_r    <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign multu_en_o = multu_en_r;
    assign hi_we_o    = hi_we_r;
    assign lo_we_o    = lo_we_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign stall_o    = stall_s;

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles spent stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed-vector bench for alu_issue_ctrl (MUL_CYCLES = 32). Inputs are
// driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;
    import alu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_i;
    logic [5:0] funct_i;
    logic [2:0] alu_op_o;
    logic [1:0] mux_sel_o;
    logic       sht_en_o;
    logic       multu_en_o;
    logic       hi_we_o;
    logic       lo_we_o;
    logic       stall_o;
    logic       busy_o;
    logic       done_o;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int test_cnt = 0;
    int fail_cnt = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.MUL_CYCLES(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .funct_i    (funct_i),
        .alu_op_o   (alu_op_o),
        .mux_sel_o  (mux_sel_o),
        .sht_en_o   (sht_en_o),
        .multu_en_o (multu_en_o),
        .hi_we_o    (hi_we_o),
        .lo_we_o    (lo_we_o),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Decode table: valid, funct, expected {alu_op, mux_sel, sht_en}
    localparam int NDEC = 11;
    logic       d_valid [NDEC] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0] d_funct [NDEC] = '{6'd36, 6'd37, 6'd34, 6'd42, 6'd0, 6'd16, 6'd18, 6'd8, 6'd32, 6'd63, 6'd0};
    logic [5:0] d_exp   [NDEC] = '{6'b000_00_0, 6'b001_00_0, 6'b110_00_0, 6'b111_00_0, 6'b010_11_1,
                                   6'b010_01_0, 6'b010_10_0, 6'b010_00_0, 6'b010_00_0, 6'b010_00_0,
                                   6'b010_00_0};

    logic e_mul, e_wb, e_busy, e_stall;

    initial begin
        rst     = 1'b0;
        valid_i = 1'b1;
        funct_i = 6'd32;
        tick;
        tick;
        // Reset state with ADD in EX
        check_val("rst_regs", {27'd0, multu_en_o, hi_we_o, lo_we_o, busy_o, done_o}, 32'd0);
        check_val("rst_dec", {26'd0, alu_op_o, mux_sel_o, sht_en_o}, {26'd0, 6'b010_00_0});
        check_val("rst_stall", {31'd0, stall_o}, 32'd0);
`ifdef STALL_CNT_EN
        check_val("rst_scnt", stall_cnt_o, 32'd0);
`endif
        rst = 1'b1;

        // Combinational decode
        for (int i = 0; i < NDEC; i++) begin
            tick;
            valid_i = d_valid[i];
            funct_i = d_funct[i];
            #1;
            check_val($sformatf("dec%0d", i), {25'd0, alu_op_o, mux_sel_o, sht_en_o, stall_o},
                      {25'd0, d_exp[i], 1'b0});
        end

        // MULTU run with ADD then MFHI behind it
        tick;
        valid_i = 1'b1;
        funct_i = 6'd25;
        #1;
        check_val("acc_stall", {31'd0, stall_o}, 32'd0);
        for (int k = 1; k <= 34; k++) begin
            tick;
            funct_i = (k == 1) ? 6'd32 : 6'd16;
            #1;
            e_mul   = (k <= 32);
            e_wb    = (k == 33);
            e_busy  = (k <= 33);
            e_stall = (k >= 2) && (k <= 33);
            check_val($sformatf("run1_regs_k%0d", k), {27'd0, multu_en_o, hi_we_o, lo_we_o, busy_o, done_o},
                      {27'd0, e_mul, e_wb, e_wb, e_busy, e_wb});
            check_val($sformatf("run1_stall_k%0d", k), {31'd0, stall_o}, {31'd0, e_stall});
        end
        check_val("mfhi_sel", {30'd0, mux_sel_o}, {30'd0, 2'b01});
`ifdef STALL_CNT_EN
        check_val("run1_scnt", stall_cnt_o, 32'd32);
`endif

        // Back-to-back MULTU: second one waits through MUL and WB
        tick;
        valid_i = 1'b1;
        funct_i = 6'd25;
        #1;
        check_val("acc2_stall", {31'd0, stall_o}, 32'd0);
        for (int k = 1; k <= 68; k++) begin
            tick;
            valid_i = (k <= 34);
            funct_i = 6'd25;
            #1;
            e_mul   = (k <= 32) || ((k >= 35) && (k <= 66));
            e_wb    = (k == 33) || (k == 67);
            e_busy  = (k <= 33) || ((k >= 35) && (k <= 67));
            e_stall = (k <= 33);
            check_val($sformatf("run2_regs_k%0d", k), {27'd0, multu_en_o, hi_we_o, lo_we_o, busy_o, done_o},
                      {27'd0, e_mul, e_wb, e_wb, e_busy, e_wb});
            check_val($sformatf("run2_stall_k%0d", k), {31'd0, stall_o}, {31'd0, e_stall});
        end
`ifdef STALL_CNT_EN
        check_val("run2_scnt", stall_cnt_o, 32'd65);
`endif

        // Reset in the middle of a multiply
        tick;
        valid_i = 1'b1;
        funct_i = 6'd25;
        for (int k = 1; k <= 10; k++) begin
            tick;
            valid_i = 1'b0;
            #1;
            check_val($sformatf("abort_run_k%0d", k), {27'd0, multu_en_o, hi_we_o, lo_we_o, busy_o, done_o},
                      {27'd0, 5'b10010});
        end
        rst = 1'b0;
        tick;
        check_val("abort_regs", {27'd0, multu_en_o, hi_we_o, lo_we_o, busy_o, done_o}, 32'd0);
`ifdef STALL_CNT_EN
        check_val("abort_scnt", stall_cnt_o, 32'd0);
`endif
        rst = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick;
            check_val($sformatf("post_abort_k%0d", k), {27'd0, multu_en_o, hi_we_o, lo_we_o, busy_o, done_o},
                      32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
